// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_W-bit frame per accepted start, MSB first, full duplex.
// done rises (2*DATA_W+2)*CLK_DIV+1 cycles after accept; start is ignored while a frame is in flight.
module spi_master #(
    parameter int DATA_W  = 11,
    parameter int CLK_DIV = 4
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              MISO,
    output logic              CS,
    output logic              spi_clk,
    output logic              MOSI,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                cs_q, cs_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                div_wrap;

    assign div_wrap = (div_q == DIV_MAX);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cs_d  = 1'b0;
                sck_d = 1'b0;
                if (start) begin
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    mosi_d  = tx_data[DATA_W-1];
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            XFER: begin
                if (div_wrap) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // rising edge: capture the slave's bit
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], MISO};
                        bit_d   = bit_q + 1'b1;
                    end else if (bit_q < BIT_MAX) begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            HOLD: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                cs_d      = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                mosi_d    = 1'b0;
                rx_data_d = rx_sh_q;
                bit_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            cs_q      <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CS      = cs_q;
    assign spi_clk = sck_q;
    assign MOSI    = mosi_q;
    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
